// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner: synchroniser, debounce FSM and edge strobes per channel.
// Optional long-press strobe built only when BUTTON_LONG_PRESS_EN is defined.
module button_debounce_multi #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_CYCLES   = 2_000_000,
   parameter int unsigned LONG_CYCLES = 100_000_000
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] noisy,
   output logic [N_CH-1:0] debounce,
   output logic [N_CH-1:0] p_edge,
   output logic [N_CH-1:0] n_edge,
   output logic [N_CH-1:0] any_edge,
   output logic [N_CH-1:0] long_press
);

   if (N_CH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_params
      $error("button_debounce_multi: illegal parameter value");
   end

   localparam int unsigned    CW       = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

   logic [SYNC_STAGES-1:0] sync_q [N_CH];
   logic [N_CH-1:0]        s;

   state_t          state_q [N_CH];
   state_t          state_d [N_CH];
   logic [CW-1:0]   cnt_q   [N_CH];
   logic [CW-1:0]   cnt_d   [N_CH];

   logic [N_CH-1:0] debounce_q, debounce_d;
   logic [N_CH-1:0] p_edge_q, p_edge_d;
   logic [N_CH-1:0] n_edge_q, n_edge_d;
   logic [N_CH-1:0] any_edge_q, any_edge_d;

   always_comb begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
         s[ch] = sync_q[ch][SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
         if (!reset_n) sync_q[ch] <= '0;
         else          sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], noisy[ch]};
      end
   end

   // State register (FSM state, qualification counter and registered outputs)
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned ch = 0; ch < N_CH; ch++) begin
            state_q[ch] <= LOW;
            cnt_q[ch]   <= '0;
         end
         debounce_q <= '0;
         p_edge_q   <= '0;
         n_edge_q   <= '0;
         any_edge_q <= '0;
      end else begin
         for (int unsigned ch = 0; ch < N_CH; ch++) begin
            state_q[ch] <= state_d[ch];
            cnt_q[ch]   <= cnt_d[ch];
         end
         debounce_q <= debounce_d;
         p_edge_q   <= p_edge_d;
         n_edge_q   <= n_edge_d;
         any_edge_q <= any_edge_d;
      end
   end

   always_comb begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
         state_d[ch] = state_q[ch];
         cnt_d[ch]   = cnt_q[ch];
         unique case (state_q[ch])
            LOW: begin
               cnt_d[ch] = '0;
               if (s[ch]) begin
                  state_d[ch] = WAIT_HIGH;
                  cnt_d[ch]   = CW'(1);
               end
            end
            WAIT_HIGH: begin
               if (!s[ch]) begin
                  state_d[ch] = LOW;
                  cnt_d[ch]   = '0;
               end else if (cnt_q[ch] == CNT_LAST) begin
                  state_d[ch] = HIGH;
                  cnt_d[ch]   = '0;
               end else begin
                  cnt_d[ch]   = cnt_q[ch] + CW'(1);
               end
            end
            HIGH: begin
               cnt_d[ch] = '0;
               if (!s[ch]) begin
                  state_d[ch] = WAIT_LOW;
                  cnt_d[ch]   = CW'(1);
               end
            end
            WAIT_LOW: begin
               if (s[ch]) begin
                  state_d[ch] = HIGH;
                  cnt_d[ch]   = '0;
               end else if (cnt_q[ch] == CNT_LAST) begin
                  state_d[ch] = LOW;
                  cnt_d[ch]   = '0;
               end else begin
                  cnt_d[ch]   = cnt_q[ch] + CW'(1);
               end
            end
            default: begin
               state_d[ch] = LOW;
               cnt_d[ch]   = '0;
            end
         endcase
      end
   end

   // Strobes fire only on a qualified WAIT_* -> stable transition, never on bounce or reset
   always_comb begin
      debounce_d = '0;
      p_edge_d   = '0;
      n_edge_d   = '0;
      any_edge_d = '0;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
         debounce_d[ch] = (state_d[ch] == HIGH) || (state_d[ch] == WAIT_LOW);
         p_edge_d[ch]   = (state_q[ch] == WAIT_HIGH) && (state_d[ch] == HIGH);
         n_edge_d[ch]   = (state_q[ch] == WAIT_LOW) && (state_d[ch] == LOW);
         any_edge_d[ch] = p_edge_d[ch] | n_edge_d[ch];
      end
   end

   assign debounce = debounce_q;
   assign p_edge   = p_edge_q;
   assign n_edge   = n_edge_q;
   assign any_edge = any_edge_q;

`ifdef BUTTON_LONG_PRESS_EN
   localparam int unsigned   HW       = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

   logic [HW-1:0]   hold_q [N_CH];
   logic [HW-1:0]   hold_d [N_CH];
   logic [N_CH-1:0] long_q, long_d;

   // Saturating hold count; the pulse marks the single step onto HOLD_MAX
   always_comb begin
      long_d = '0;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
         hold_d[ch] = hold_q[ch];
         if (!debounce_q[ch])            hold_d[ch] = '0;
         else if (hold_q[ch] != HOLD_MAX) hold_d[ch] = hold_q[ch] + HW'(1);
         long_d[ch] = debounce_q[ch] && (hold_q[ch] == HOLD_MAX - HW'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned ch = 0; ch < N_CH; ch++) hold_q[ch] <= '0;
         long_q <= '0;
      end else begin
         for (int unsigned ch = 0; ch < N_CH; ch++) hold_q[ch] <= hold_d[ch];
         long_q <= long_d;
      end
   end

   assign long_press = long_q;
`else
   assign long_press = '0;
`endif

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed table-driven bench for button_debounce_multi (N_CH=4, DB_CYCLES=8, LONG_CYCLES=32),
// plus hand-written long-press sequences for both BUTTON_LONG_PRESS_EN builds.
module tb_button_debounce_multi;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] noisy;
   logic [3:0] debounce, p_edge, n_edge, any_edge, long_press;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   typedef struct {
      logic       rst_n;
      logic [3:0] nz;
      logic [3:0] deb;
      logic [3:0] pe;
      logic [3:0] ne;
      logic [3:0] ae;
   } vec_t;

   vec_t vecs[$];

   button_debounce_multi #(
      .N_CH(4),
      .SYNC_STAGES(2),
      .DB_CYCLES(8),
      .LONG_CYCLES(32)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .noisy(noisy),
      .debounce(debounce),
      .p_edge(p_edge),
      .n_edge(n_edge),
      .any_edge(any_edge),
      .long_press(long_press)
   );

   always #5 clk = ~clk;

   task automatic hold(input logic r, input logic [3:0] nz, input int reps, input logic [3:0] deb);
      vec_t v;
      for (int k = 0; k < reps; k++) begin
         v.rst_n = r; v.nz = nz; v.deb = deb; v.pe = '0; v.ne = '0; v.ae = '0;
         vecs.push_back(v);
      end
   endtask

   // New level applied: 9 edges unchanged, then the 10th edge updates debounce and strobes.
   task automatic settle(input logic [3:0] nz, input logic [3:0] old_deb, input logic [3:0] new_deb);
      vec_t v;
      hold(1'b1, nz, 9, old_deb);
      v.rst_n = 1'b1; v.nz = nz; v.deb = new_deb;
      v.pe = new_deb & ~old_deb;
      v.ne = old_deb & ~new_deb;
      v.ae = v.pe | v.ne;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int rise_at, long_at, extra;

      reset_n = 1'b0;
      noisy   = '0;

      hold(1'b0, 4'b0000, 2, 4'b0000);
      settle(4'b0001, 4'b0000, 4'b0001);
      hold(1'b1, 4'b0001, 3, 4'b0001);
      for (int k = 0; k < 5; k++) begin
         hold(1'b1, 4'b0011, 3, 4'b0001);
         hold(1'b1, 4'b0001, 3, 4'b0001);
      end
      hold(1'b1, 4'b0001, 12, 4'b0001);
      settle(4'b0000, 4'b0001, 4'b0000);
      hold(1'b1, 4'b0000, 3, 4'b0000);
      settle(4'b1111, 4'b0000, 4'b1111);
      hold(1'b1, 4'b1111, 3, 4'b1111);
      hold(1'b0, 4'b1111, 1, 4'b0000);
      settle(4'b1111, 4'b0000, 4'b1111);
      hold(1'b1, 4'b1111, 2, 4'b1111);
      // One-short glitch on the falling side, then a real release
      hold(1'b1, 4'b1110, 7, 4'b1111);
      hold(1'b1, 4'b1111, 12, 4'b1111);
      settle(4'b0000, 4'b1111, 4'b0000);
      hold(1'b1, 4'b0000, 2, 4'b0000);
      hold(1'b1, 4'b0010, 7, 4'b0000);
      hold(1'b1, 4'b0000, 12, 4'b0000);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset_n = vecs[i].rst_n;
         noisy   = vecs[i].nz;
         step();
         n_vec++;
         if (debounce !== vecs[i].deb || p_edge !== vecs[i].pe ||
             n_edge !== vecs[i].ne || any_edge !== vecs[i].ae) begin
            n_bad++;
            $display("FAIL vec%0d: deb/p/n/any got %b/%b/%b/%b expected %b/%b/%b/%b",
                     i, debounce, p_edge, n_edge, any_edge,
                     vecs[i].deb, vecs[i].pe, vecs[i].ne, vecs[i].ae);
         end
      end

      // Long-press: two separate presses on channel 2
      for (int press = 0; press < 2; press++) begin
         reset_n = (press == 0) ? 1'b0 : 1'b1;
         noisy   = '0;
         for (int k = 0; k < 12; k++) step();
         reset_n = 1'b1;
         noisy   = 4'b0100;
         rise_at = 0;
         for (int e = 1; e <= 20; e++) begin
            step();
            if (debounce[2]) begin
               rise_at = e;
               break;
            end
         end
         check("rise_latency", rise_at, 10);
         check("rise_pedge", p_edge, 4'b0100);
`ifdef BUTTON_LONG_PRESS_EN
         long_at = 0;
         for (int e = 1; e <= 40; e++) begin
            step();
            if (long_press != 4'b0000) begin
               long_at = e;
               break;
            end
         end
         check("long_latency", long_at, 32);
         check("long_value", long_press, 4'b0100);
         extra = 0;
         for (int e = 0; e < 50; e++) begin
            step();
            if (long_press != 4'b0000) extra++;
         end
         check("long_repeat", extra, 0);
`else
         long_at = 0;
         extra   = 0;
         for (int e = 0; e < 60; e++) begin
            step();
            if (long_press != 4'b0000) extra++;
         end
         check("long_tied_off", extra, long_at);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
